// File: rtl/t01_ai_feature_extract_if.sv
// Signal bundle between the placement scorer, its candidate-board RAM and the best-move tracker.
// The master side drives start/candidate/RAM data; the slave side is the scorer itself.
interface t01_ai_feature_extract_if #(
  parameter int COLS = 10
);
  logic            start;
  logic [3:0]      blockX_i;
  logic [4:0]      block_type_i;
  logic            row_rd;
  logic [4:0]      row_addr;
  logic [COLS-1:0] row_data;
  logic            busy;
  logic            done;
  logic [7:0]      lines_cleared_o;
  logic [7:0]      heights_o;
  logic [7:0]      holes_o;
  logic [7:0]      bumpiness_o;
  logic [3:0]      blockX_o;
  logic [4:0]      block_type_o;

  modport master (
    output start, blockX_i, block_type_i, row_data,
    input  row_rd, row_addr, busy, done, lines_cleared_o, heights_o,
           holes_o, bumpiness_o, blockX_o, block_type_o
  );

  modport slave (
    input  start, blockX_i, block_type_i, row_data,
    output row_rd, row_addr, busy, done, lines_cleared_o, heights_o,
           holes_o, bumpiness_o, blockX_o, block_type_o
  );
endinterface

// File: rtl/t01_ai_feature_extract.sv
// Scores one candidate board: scans the RAM top-down for column heights, holes and full
// lines, then walks adjacent columns for bumpiness and pulses done with the results.
module t01_ai_feature_extract #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  t01_ai_feature_extract_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] BUMP = 2'd2;

  logic [1:0]      state;
  logic [4:0]      rd_cnt;
  logic [4:0]      row_cnt;
  logic            data_valid;
  logic [COLS-1:0] seen;
  logic [4:0]      h [COLS];
  logic [3:0]      col;
  logic [7:0]      lines_acc;
  logic [7:0]      holes_acc;
  logic [7:0]      bump_acc;
  logic [7:0]      heights_q;
  logic [3:0]      blockx_q;
  logic [4:0]      type_q;

  logic [COLS-1:0] seen_next;
  logic [4:0]      h_next [COLS];
  logic [3:0]      hole_add;
  logic [7:0]      height_sum;
  logic [4:0]      h_a;
  logic [4:0]      h_b;
  logic [4:0]      diff;
  logic [7:0]      bump_sum;

  // Whole-row update: every column of the returned row is folded in during one cycle.
  // NOTE: every signal gets a default before the loops so no path leaves it unassigned,
  // which keeps this block purely combinational (no inferred latches).
  always_comb begin
    seen_next  = seen;
    h_next     = h;
    hole_add   = '0;
    height_sum = '0;
    for (int c = 0; c < COLS; c++) begin
      if (bus.row_data[c] && !seen[c]) begin
        seen_next[c] = 1'b1;
        h_next[c]    = 5'(ROWS) - row_cnt;
      end
      if (!bus.row_data[c] && seen[c]) hole_add = hole_add + 4'd1;
    end
    for (int c = 0; c < COLS; c++) height_sum = height_sum + {3'b000, h_next[c]};
    h_a      = h[col];
    h_b      = h[col + 4'd1];
    diff     = (h_a >= h_b) ? (h_a - h_b) : (h_b - h_a);
    bump_sum = bump_acc + {3'b000, diff};
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees the
  // pre-edge values of the others, exactly like the hardware flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      rd_cnt              <= '0;
      row_cnt             <= '0;
      data_valid          <= 1'b0;
      seen                <= '0;
      // NOTE: h is ten 5-bit flops, not a RAM, so resetting it is cheap and keeps the
      // scorer deterministic; a real memory array would be left unreset.
      for (int c = 0; c < COLS; c++) h[c] <= '0;
      col                 <= '0;
      lines_acc           <= '0;
      holes_acc           <= '0;
      bump_acc            <= '0;
      heights_q           <= '0;
      blockx_q            <= '0;
      type_q              <= '0;
      bus.row_rd          <= 1'b0;
      bus.row_addr        <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.lines_cleared_o <= '0;
      bus.heights_o       <= '0;
      bus.holes_o         <= '0;
      bus.bumpiness_o     <= '0;
      bus.blockX_o        <= '0;
      bus.block_type_o    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            blockx_q     <= bus.blockX_i;
            type_q       <= bus.block_type_i;
            lines_acc    <= '0;
            holes_acc    <= '0;
            bump_acc     <= '0;
            seen         <= '0;
            for (int c = 0; c < COLS; c++) h[c] <= '0;
            row_cnt      <= '0;
            data_valid   <= 1'b0;
            // Row 0 is requested on the start edge itself; rd_cnt tracks the next row.
            bus.row_rd   <= 1'b1;
            bus.row_addr <= '0;
            rd_cnt       <= 5'd1;
            bus.busy     <= 1'b1;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (rd_cnt < 5'(ROWS)) begin
            bus.row_rd   <= 1'b1;
            bus.row_addr <= rd_cnt;
            rd_cnt       <= rd_cnt + 5'd1;
          end else begin
            bus.row_rd   <= 1'b0;
            bus.row_addr <= '0;
          end
          data_valid <= bus.row_rd;
          if (data_valid) begin
            seen      <= seen_next;
            h         <= h_next;
            holes_acc <= holes_acc + {4'b0000, hole_add};
            if (bus.row_data == {COLS{1'b1}}) lines_acc <= lines_acc + 8'd1;
            row_cnt   <= row_cnt + 5'd1;
            if (row_cnt == 5'(ROWS - 1)) begin
              heights_q <= height_sum;
              col       <= '0;
              state     <= BUMP;
            end
          end
        end
        BUMP: begin
          if (col == 4'(COLS - 2)) begin
            bus.lines_cleared_o <= lines_acc;
            bus.heights_o       <= heights_q;
            bus.holes_o         <= holes_acc;
            bus.bumpiness_o     <= bump_sum;
            bus.blockX_o        <= blockx_q;
            bus.block_type_o    <= type_q;
            bus.done            <= 1'b1;
            bus.busy            <= 1'b0;
            state               <= IDLE;
          end else begin
            bump_acc <= bump_sum;
            col      <= col + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_t01_ai_feature_extract.sv
// Bench for the placement scorer: directed boards from the plan plus random boards, all
// compared against a column-wise reference model of the board metrics.
module tb_t01_ai_feature_extract;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  t01_ai_feature_extract_if bus ();

  t01_ai_feature_extract dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [9:0] mem [20];

  // Candidate-board RAM: data valid the cycle after the strobe.
  always @(posedge clk) if (bus.row_rd && bus.row_addr < 5'd20) bus.row_data <= mem[bus.row_addr];

  int checks = 0;
  int errors = 0;
  int exp_lines, exp_heights, exp_holes, exp_bump;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: per column, height from the topmost filled cell, holes are empties under it.
  function automatic void model();
    int ht [10];
    exp_lines = 0; exp_heights = 0; exp_holes = 0; exp_bump = 0;
    for (int r = 0; r < 20; r++) if (mem[r] == 10'h3FF) exp_lines++;
    for (int c = 0; c < 10; c++) begin
      bit found = 0;
      ht[c] = 0;
      for (int r = 0; r < 20; r++) begin
        if (mem[r][c] && !found) begin found = 1; ht[c] = 20 - r; end
        else if (!mem[r][c] && found) exp_holes++;
      end
      exp_heights += ht[c];
    end
    for (int c = 0; c < 9; c++) exp_bump += (ht[c] > ht[c+1]) ? ht[c] - ht[c+1] : ht[c+1] - ht[c];
  endfunction

  task automatic clear_mem();
    for (int r = 0; r < 20; r++) mem[r] = '0;
  endtask

  task automatic random_mem();
    int cutoff = $urandom_range(0, 19);
    for (int r = 0; r < 20; r++)
      mem[r] = (r < cutoff) ? 10'h000 : (($urandom_range(0, 5) == 0) ? 10'h3FF : 10'($urandom));
  endtask

  // Drives a one-cycle start; returns just after E0.
  task automatic kick(input int bx, input int bt);
    bus.start        = 1'b1;
    bus.blockX_i     = 4'(bx);
    bus.block_type_i = 5'(bt);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Follows one scan from just after E0 until done; returns just after the done edge.
  task automatic wait_result(input string tag, input int exp_bx, input int exp_bt, input bit inject);
    int rd = 0, bad = 0, lat = -1;
    check({tag, "_busy"}, bus.busy, 1);
    for (int k = 0; k < 60; k++) begin
      if (bus.row_rd) begin
        if (bus.row_addr != 5'(rd)) bad++;
        rd++;
      end
      if (bus.done) begin lat = k; break; end
      if (inject) begin
        bus.start = (k == 10);
        if (k == 10) bus.blockX_i = 4'(exp_bx + 1);
      end
      @(posedge clk); #1;
    end
    if (inject) bus.start = 1'b0;
    check({tag, "_latency"}, lat, 30);
    check({tag, "_reads"}, rd, 20);
    check({tag, "_addr_seq_bad"}, bad, 0);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_lines"}, bus.lines_cleared_o, exp_lines);
    check({tag, "_heights"}, bus.heights_o, exp_heights);
    check({tag, "_holes"}, bus.holes_o, exp_holes);
    check({tag, "_bump"}, bus.bumpiness_o, exp_bump);
    check({tag, "_blockx"}, bus.blockX_o, exp_bx);
    check({tag, "_type"}, bus.block_type_o, exp_bt);
  endtask

  task automatic expect_const(input string tag, input int l, input int ht, input int ho, input int b);
    check({tag, "_lines_k"}, bus.lines_cleared_o, l);
    check({tag, "_heights_k"}, bus.heights_o, ht);
    check({tag, "_holes_k"}, bus.holes_o, ho);
    check({tag, "_bump_k"}, bus.bumpiness_o, b);
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, bus.done, 0);
    check({tag, "_rd_idle"}, bus.row_rd, 0);
  endtask

  task automatic run(input string tag, input int bx, input int bt);
    model();
    @(negedge clk);
    kick(bx, bt);
    wait_result(tag, bx, bt, 1'b0);
    pulse_end(tag);
  endtask

  initial begin
    int done_seen;
    bus.start = 1'b0; bus.blockX_i = '0; bus.block_type_i = '0;
    clear_mem();
    rst = 1'b1;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_row_rd", bus.row_rd, 0);
    check("rst_row_addr", bus.row_addr, 0);
    expect_const("rst", 0, 0, 0, 0);
    check("rst_blockx", bus.blockX_o, 0);
    check("rst_type", bus.block_type_o, 0);
    @(negedge clk); rst = 1'b0;

    clear_mem();
    run("empty", 3, 5);
    expect_const("empty", 0, 0, 0, 0);

    clear_mem(); mem[18] = 10'h3FF; mem[19] = 10'h3FF;
    run("bottom2", 6, 1);
    expect_const("bottom2", 2, 20, 0, 0);

    clear_mem(); mem[15] = 10'h001;
    run("column", 0, 2);
    expect_const("column", 0, 5, 4, 5);

    clear_mem(); mem[19] = 10'h3FF; mem[18] = 10'h001; mem[17] = 10'h001;
    run("stair", 9, 17);
    expect_const("stair", 1, 12, 0, 2);

    // Start mid-scan must be ignored.
    random_mem(); model();
    @(negedge clk); kick(7, 9);
    wait_result("inject", 7, 9, 1'b1);
    pulse_end("inject");

    // Back-to-back: next start sampled on the edge after done.
    random_mem(); model();
    @(negedge clk); kick(1, 2);
    wait_result("b2b_a", 1, 2, 1'b0);
    random_mem(); model();
    kick(4, 11);
    wait_result("b2b_b", 4, 11, 1'b0);
    pulse_end("b2b_b");

    // Reset mid-scan: outputs clear at once and no done follows.
    random_mem();
    @(negedge clk); kick(5, 6);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_row_rd", bus.row_rd, 0);
    expect_const("midrst", 0, 0, 0, 0);
    check("midrst_blockx", bus.blockX_o, 0);
    done_seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    random_mem();
    run("after_rst", 5, 6);

    for (int i = 0; i < 10; i++) begin
      random_mem();
      run($sformatf("rand%0d", i), $urandom_range(0, 15), $urandom_range(0, 31));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
